// File: rtl/cmd_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cmd_queue: FWFT command FIFO between UART_wrapper and cmd_proc    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module cmd_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_cmd,
  input  logic             in_cmd_rdy,
  output logic             in_clr_cmd_rdy,
  output logic [15:0]      out_cmd,
  output logic             out_cmd_rdy,
  input  logic             out_clr_cmd_rdy,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic [PTR_W:0]   hwm
);

  localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  logic [15:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   r_hwm;
  logic             r_clr;

  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;
  logic [PTR_W:0]   w_count_nxt;
  logic [PTR_W:0]   w_hwm_nxt;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

  // r_clr masks the cycle in which UART_wrapper is still dropping cmd_rdy
  assign w_wr = in_cmd_rdy & ~r_clr & ~w_full & ~flush;
  assign w_rd = out_clr_cmd_rdy & ~w_empty & ~flush;

  always_comb begin
    w_count_nxt = r_count;
    if (flush)
      w_count_nxt = '0;
    else if (w_wr && !w_rd)
      w_count_nxt = r_count + C_CNT_ONE;
    else if (w_rd && !w_wr)
      w_count_nxt = r_count - C_CNT_ONE;
  end

  always_comb begin
    w_hwm_nxt = r_hwm;
    if (flush)
      w_hwm_nxt = '0;
    else if (w_count_nxt > r_hwm)
      w_hwm_nxt = w_count_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hwm    <= '0;
      r_clr    <= 1'b0;
    end else begin
      if (w_wr)
        r_mem[r_wr_ptr] <= in_cmd;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr)
          r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        if (w_rd)
          r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_hwm   <= w_hwm_nxt;
      r_clr   <= w_wr;
    end
  end

  assign in_clr_cmd_rdy = r_clr;
  assign out_cmd        = r_mem[r_rd_ptr];
  assign out_cmd_rdy    = ~w_empty;
  assign full           = w_full;
  assign empty          = w_empty;
  assign count          = r_count;
  assign hwm            = r_hwm;

endmodule
`default_nettype wire

// File: tb/tb_cmd_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cmd_queue: directed bench with a queue-based reference model   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_cmd_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      in_cmd = '0;
  logic             in_cmd_rdy = 1'b0;
  logic             in_clr_cmd_rdy;
  logic [15:0]      out_cmd;
  logic             out_cmd_rdy;
  logic             out_clr_cmd_rdy = 1'b0;
  logic             flush = 1'b0;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   hwm;

  int checks = 0;
  int errors = 0;

  cmd_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_cmd(in_cmd), .in_cmd_rdy(in_cmd_rdy), .in_clr_cmd_rdy(in_clr_cmd_rdy),
    .out_cmd(out_cmd), .out_cmd_rdy(out_cmd_rdy), .out_clr_cmd_rdy(out_clr_cmd_rdy),
    .flush(flush), .full(full), .empty(empty), .count(count), .hwm(hwm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held commands plus the ack pulse
  logic [15:0] mq[$];
  bit          m_clr = 1'b0;
  int          m_hwm = 0;
  bit          m_wr, m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_clr = 1'b0;
      m_hwm = 0;
    end else begin
      m_wr = in_cmd_rdy && !m_clr && (mq.size() < DEPTH) && !flush;
      m_rd = out_clr_cmd_rdy && (mq.size() != 0) && !flush;
      if (flush) begin
        mq.delete();
        m_clr = 1'b0;
        m_hwm = 0;
      end else begin
        if (m_rd) mq.delete(0);
        if (m_wr) mq.push_back(in_cmd);
        m_clr = m_wr;
        if (mq.size() > m_hwm) m_hwm = mq.size();
      end
    end
  end

  always @(negedge clk) begin
    check("empty", int'(empty), int'(mq.size() == 0));
    check("full", int'(full), int'(mq.size() == DEPTH));
    check("count", int'(count), mq.size());
    check("hwm", int'(hwm), m_hwm);
    check("out_cmd_rdy", int'(out_cmd_rdy), int'(mq.size() != 0));
    check("in_clr_cmd_rdy", int'(in_clr_cmd_rdy), int'(m_clr));
    if (mq.size() != 0)
      check("out_cmd", int'(out_cmd), int'(mq[0]));
  end

  task automatic send(input logic [15:0] c);
    bit seen = 1'b0;
    @(negedge clk); #2;
    in_cmd = c;
    in_cmd_rdy = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (in_clr_cmd_rdy) seen = 1'b1;
    end
    check("send_ack_timeout", int'(seen), 1);
    #2 in_cmd_rdy = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk); #2 out_clr_cmd_rdy = 1'b1;
    @(negedge clk); #2 out_clr_cmd_rdy = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk); #2 flush = 1'b1;
    @(negedge clk); #2 flush = 1'b0;
  endtask

  logic [15:0] burst [5];

  initial begin
    burst[0] = 16'h4000; burst[1] = 16'h6001; burst[2] = 16'h2000;
    burst[3] = 16'h4FFF; burst[4] = 16'h6003;

    // 1: reset then idle
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_empty", int'(empty), 1);
    check("t1_rdy", int'(out_cmd_rdy), 0);
    check("t1_clr", int'(in_clr_cmd_rdy), 0);
    check("t1_count", int'(count), 0);
    check("t1_hwm", int'(hwm), 0);

    // 2: single command
    send(16'h4000);
    check("t2_out_cmd", int'(out_cmd), 16'h4000);
    check("t2_out_rdy", int'(out_cmd_rdy), 1);
    @(negedge clk);
    check("t2_single_pulse", int'(in_clr_cmd_rdy), 0);
    pop();
    check("t2_empty", int'(empty), 1);

    // 3: burst of five against a depth-4 queue
    for (int i = 0; i < 4; i++) send(burst[i]);
    check("t3_full", int'(full), 1);
    check("t3_count", int'(count), 4);
    @(negedge clk); #2;
    in_cmd = burst[4];
    in_cmd_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_held_no_clr", int'(in_clr_cmd_rdy), 0);
    end
    check("t3_head0", int'(out_cmd), 16'h4000);
    pop();
    check("t3_count_after_pop", int'(count), 3);
    @(negedge clk);
    check("t3_fifth_captured", int'(in_clr_cmd_rdy), 1);
    #2 in_cmd_rdy = 1'b0;
    for (int i = 1; i < 5; i++) begin
      check("t3_order", int'(out_cmd), int'(burst[i]));
      pop();
    end
    check("t3_drained", int'(empty), 1);
    check("t3_hwm", int'(hwm), 4);

    // 4: full, pop and cmd_rdy in the same clock
    for (int i = 1; i <= 4; i++) send(16'hA000 + 16'(i));
    @(negedge clk); #2;
    in_cmd = 16'hA005;
    in_cmd_rdy = 1'b1;
    out_clr_cmd_rdy = 1'b1;
    @(negedge clk);
    check("t4_count_pop", int'(count), 3);
    check("t4_no_clr_yet", int'(in_clr_cmd_rdy), 0);
    check("t4_head", int'(out_cmd), 16'hA002);
    #2 out_clr_cmd_rdy = 1'b0;
    @(negedge clk);
    check("t4_capture", int'(in_clr_cmd_rdy), 1);
    check("t4_count_back", int'(count), 4);
    #2 in_cmd_rdy = 1'b0;
    @(negedge clk);
    check("t4_no_double", int'(in_clr_cmd_rdy), 0);
    check("t4_count_stays", int'(count), 4);
    do_flush();

    // 5: pop while empty, then a push
    pop();
    check("t5_count", int'(count), 0);
    send(16'h1234);
    check("t5_readback", int'(out_cmd), 16'h1234);
    pop();

    // 6: flush with 3 entries, then reset during a capture
    send(16'h0111); send(16'h0222); send(16'h0333);
    check("t6_count3", int'(count), 3);
    do_flush();
    check("t6_empty", int'(empty), 1);
    check("t6_hwm", int'(hwm), 0);
    check("t6_out_rdy", int'(out_cmd_rdy), 0);
    @(negedge clk); #2;
    in_cmd = 16'hBEEF;
    in_cmd_rdy = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("t6_clr_cancelled", int'(in_clr_cmd_rdy), 0);
    check("t6_reset_count", int'(count), 0);
    repeat (2) begin
      @(negedge clk);
      check("t6_clr_in_reset", int'(in_clr_cmd_rdy), 0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t6_capture_after_reset", int'(in_clr_cmd_rdy), 1);
    check("t6_count1", int'(count), 1);
    #2 in_cmd_rdy = 1'b0;
    @(negedge clk);
    check("t6_readback", int'(out_cmd), 16'hBEEF);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
